mult_mnbit_seq: RTL and testbench
=================================

// Module: mult_mnbit_seq
// PURPOSE
// - Sequential M x N shift-add multiplier, successor to the combinational array multiplier.
// - Folds the N partial-product rows onto one M-bit ripple adder; retires one row per clock.
// - Valid/ready handshakes on both sides let it sit between producer and consumer stages.
// - Trades N cycles of latency for about 1/N of the adder area.
// PARAMETERS
// - M   4   multiplicand (A) width, M >= 2
// - N   4   multiplier (B) width, N >= 2; equals the number of iteration cycles
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      operands valid
// - in_ready   out  1      block can accept operands
// - A          in   M      multiplicand
// - B          in   N      multiplier
// - out_valid  out  1      product valid
// - out_ready  in   1      consumer accepts product
// - product    out  M+N    A*B
// - busy       out  1      high while in BUSY
// BEHAVIOUR
// - Reset (async assert, sync release) forces state IDLE, count=0, accumulator=0.
//   Output reset values: in_ready=1, out_valid=0, product=0, busy=0.
// - FSM states:
//   - IDLE: in_ready=1. On (in_valid & in_ready) latch A into a_reg and B into the low N bits
//     of the accumulator, zero its upper M bits, set count=0, go to BUSY.
//   - BUSY: in_ready=0, busy=1. Each cycle:
//     - if acc[0]=1, upper = upper + a_reg on an (M+1)-bit sum; else add 0;
//     - shift the (M+1+N)-bit {carry, upper, lower} right by 1;
//     - count++.
//     After N BUSY cycles, go to DONE.
//   - DONE: out_valid=1, product = acc[M+N-1:0], held stable.
//     On out_ready go to IDLE, out_valid drops next cycle.
// - Latency: out_valid rises N clock edges after the accepting edge.
// - Throughput: one result per N+2 cycles minimum.
// - Back-pressure: DONE persists indefinitely while out_ready=0; product and out_valid do not change.
// - in_valid while not IDLE is ignored; operand inputs are sampled only on the accepting edge.
// - in_valid and out_ready both high in DONE: only the output handshake completes.
//   The new operand is accepted no earlier than the following IDLE cycle.
// - No overflow is possible: M+N bits always hold the full result.
//   The carry bit of the (M+1)-bit sum is shifted into the accumulator, never dropped.
// - Zero operands still take the full N cycles; there is no early termination.
// - rst_n low mid-BUSY or mid-DONE aborts the operation: outputs return to reset values
//   immediately and the partial result is discarded.
// - count width = $clog2(N+1).
// - product is registered; no combinational path from inputs to any output.
// CONFIGURATION
// - MULT_SIGNED_EN defined: A, B and product are two's complement.
//   - a_reg is sign-extended to M+1 bits.
//   - The shift is arithmetic: the vacated MSB takes the sign of the (M+1)-bit sum, not the carry.
//   - In the final BUSY cycle (count=N-1, B sign bit) a_reg is subtracted instead of added.
//   - Latency and handshake are unchanged.
// - MULT_SIGNED_EN undefined: unsigned operation as above; there is no subtract path.
// TESTING
// - M=N=4 unsigned: A=13, B=11 -> out_valid 4 edges after accept, product=8'h8F.
// - M=N=4 unsigned: A=15, B=15 -> 8'hE1. A=0, B=9 -> 8'h00, still 4 cycles of busy.
// - M=8, N=4: A=255, B=15 -> product=12'hEF1.
//   Exhaustive sweep for M=N=4 checked against a reference model.
// - Back-pressure: hold out_ready=0 for 10 cycles in DONE -> product and out_valid stable,
//   in_ready=0, further in_valid ignored; out_ready=1 -> IDLE next cycle.
// - Reset mid-op: assert rst_n=0 at count=2 -> outputs immediately at reset values.
//   After release, a new A=3, B=5 yields 8'h0F.
// - MULT_SIGNED_EN, M=N=4: A=-3, B=5 -> 8'hF1; A=-8, B=-8 -> 8'h40; A=7, B=-1 -> 8'hF9.

Source files
------------

// File: rtl/mult_mnbit_seq.sv
// Sequential M x N shift-add multiplier: one partial-product row is retired per clock.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module mult_mnbit_seq #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M+N-1:0]   product,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid is held with its data until ready is seen, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(N + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [M-1:0]    a_reg;
  logic [M+N-1:0]  acc;
  logic [M:0]      upper_ext, a_ext, sum;
  logic            last;

  assign last = (count == CW'(N - 1));

  always_comb begin
`ifdef MULT_SIGNED_EN
    upper_ext = {acc[M+N-1], acc[M+N-1:N]};
    a_ext     = {a_reg[M-1], a_reg};
    // The multiplier sign bit carries weight -2^(N-1), so its row is subtracted.
    if (!acc[0])
      sum = upper_ext;
    else if (last)
      sum = upper_ext - a_ext;
    else
      sum = upper_ext + a_ext;
`else
    upper_ext = {1'b0, acc[M+N-1:N]};
    a_ext     = {1'b0, a_reg};
    sum       = acc[0] ? (upper_ext + a_ext) : upper_ext;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      a_reg <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_reg <= A;
        acc   <= {{M{1'b0}}, B};
        count <= '0;
      end else if (state == BUSY) begin
        // {sum, lower} shifted right by one; sum's top bit (carry or sign) is kept.
        acc   <= {sum, acc[N-1:1]};
        count <= count + CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign product   = acc;
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_mnbit_seq.sv
// Bench for mult_mnbit_seq (M=N=4): directed vectors, full operand sweep, back-pressure, reset abort.
module tb_mult_mnbit_seq;
  localparam int M = 4;
  localparam int N = 4;
  localparam int W = M + N;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [M-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           in_ready, out_valid, busy;
  logic [W-1:0]   product;
  logic [1:0]     dbg_state;

  mult_mnbit_seq #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MULT_SIGNED_EN
  localparam int NV = 6;
  logic [M-1:0] va [NV] = '{4'hD, 4'h8, 4'h7, 4'h3, 4'hF, 4'h0};
  logic [N-1:0] vb [NV] = '{4'h5, 4'h8, 4'hF, 4'h5, 4'hF, 4'h7};
  logic [W-1:0] vp [NV] = '{8'hF1, 8'h40, 8'hF9, 8'h0F, 8'h01, 8'h00};
`else
  localparam int NV = 7;
  logic [M-1:0] va [NV] = '{4'hD, 4'hF, 4'h0, 4'h3, 4'h1, 4'hF, 4'h8};
  logic [N-1:0] vb [NV] = '{4'hB, 4'hF, 4'h9, 4'h5, 4'h1, 4'h1, 4'h2};
  logic [W-1:0] vp [NV] = '{8'h8F, 8'hE1, 8'h00, 8'h0F, 8'h01, 8'h0F, 8'h10};
`endif

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mul(input int x, input int y);
    int sx, sy;
    sx = x;
    sy = y;
`ifdef MULT_SIGNED_EN
    if (x >= (1 << (M - 1))) sx = x - (1 << M);
    if (y >= (1 << (N - 1))) sy = y - (1 << N);
`endif
    return W'(sx * sy);
  endfunction

  // monitor
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_ov) begin
      if (lat_q.size() == 0) begin
        total++; bad++;
        $display("FAIL latency: out_valid rose with no accepted operands (t=%0t)", $time);
      end else begin
        chk("latency", W'(cyc - lat_q.pop_front()), W'(N));
      end
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL product: unexpected output %h", product);
      end else begin
        chk("product", product, exp_q.pop_front());
      end
    end
    prev_ov <= out_valid;
  end

  // driver tasks
  task automatic send(input logic [M-1:0] av, input logic [N-1:0] bv, input logic [W-1:0] want);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
      return;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    exp_q.push_back(want);
    @(negedge clk);
    lat_q.push_back(cyc);
    in_valid = 1'b0;
    chk("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(exp_q.size() == 0 && in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: pending got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_product", product, W'(0));
    chk("reset_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) send(va[i], vb[i], vp[i]);
    for (int i = 0; i < (1 << M); i++)
      for (int j = 0; j < (1 << N); j++)
        send(M'(i), N'(j), ref_mul(i, j));
    wait_idle();

    // back-pressure with competing operands held on the input
    out_ready = 1'b0;
    send(va[0], vb[0], vp[0]);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_reach_done", W'(out_valid), W'(1));
    in_valid = 1'b1;
    a = 4'h2;
    b = 4'h3;
    repeat (10) begin
      @(negedge clk);
      chk("bp_product", product, vp[0]);
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    chk("bp_release_out_valid", W'(out_valid), W'(0));
    exp_q.push_back(8'h06);
    @(negedge clk);
    lat_q.push_back(cyc);
    in_valid = 1'b0;
    chk("bp_next_accept", W'(busy), W'(1));
    wait_idle();

    // reset mid-operation at count=2
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'h9;
    b = 4'h7;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_product", product, W'(0));
    chk("abort_state", W'(dbg_state), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h3, 4'h5, 8'h0F);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("leftover", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
